load_extend_ctrl: RTL and testbench

- Load-path controller between the core's load request and data memory.
- Accepts byte, halfword and word load requests, issues one aligned word read and waits for the memory acknowledge.
- Selects the addressed lane, then sign- or zero-extends it to 32 bits.
- Returns the result on a valid/ready response channel.

---
 rtl/load_extend_pkg.sv | 28 ++
 rtl/load_extend_ctrl_lane.sv | 35 +++
 rtl/load_extend_ctrl.sv | 135 +++++++++++++
 tb/tb_load_extend_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/load_extend_pkg.sv
// Shared encodings for the load-extend controller: access sizes, FSM states
// and the request legality check used at accept time.
package load_extend_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MEM  = 2'b01,
        RESP = 2'b10
    } state_t;

    // Reserved size or an access that straddles its natural alignment.
    function automatic logic request_error(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extend_ctrl_lane.sv
// lane_extend: picks the addressed byte/half lane out of a little-endian
// read word and sign- or zero-extends it to 32 bits. Purely combinational.
module lane_extend
    import load_extend_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane select followed by extension; words pass through untouched.
    always_comb begin
        lane_b = 8'h00;
        lane_h = 16'h0000;
        data   = rdata;
        case (offset)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: data = {{24{sign_ext & lane_b[7]}}, lane_b};
            SIZE_HALF: data = {{16{sign_ext & lane_h[15]}}, lane_h};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/load_extend_ctrl.sv
// load_extend_ctrl: accepts byte/half/word loads, issues one aligned word
// read, extends the selected lane and returns it on a valid/ready channel.
// Optional memory-wait timeout: define LOAD_EXTEND_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | ready for a new request
//   MEM   | word read outstanding, waiting for mem_ack
//   RESP  | result/error held until resp_ready
module load_extend_ctrl
    import load_extend_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_err
);

    state_t      state;
    logic [1:0]  offset_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] ext_data;
    logic        req_bad;

    lane_extend u_lane (
        .rdata    (mem_rdata),
        .offset   (offset_q),
        .size     (size_q),
        .sign_ext (signed_q),
        .data     (ext_data)
    );

    // Legality of the incoming request, decided before it is latched.
    always_comb req_bad = request_error(req_size, req_addr[1:0]);

`ifdef LOAD_EXTEND_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_limit;

    // This MEM cycle is the last one allowed without an acknowledge.
    always_comb wait_limit = ((wait_cnt + 1'b1) == WAIT_LIMIT);
`endif

    // Controller FSM with all handshake outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= 1'b0;
            resp_data  <= 32'h0;
            resp_err   <= 1'b0;
            offset_q   <= 2'b00;
            size_q     <= SIZE_BYTE;
            signed_q   <= 1'b0;
`ifdef LOAD_EXTEND_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        offset_q  <= req_addr[1:0];
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        req_ready <= 1'b0;
                        if (req_bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= 32'h0;
                            resp_err   <= 1'b1;
                        end else begin
                            state    <= MEM;
                            mem_req  <= 1'b1;
                            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
`ifdef LOAD_EXTEND_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end
                    end
                end
                MEM: begin
                    if (mem_req && mem_ack) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_data  <= ext_data;
                        resp_err   <= 1'b0;
`ifdef LOAD_EXTEND_TIMEOUT_EN
                    end else if (wait_limit) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_data  <= 32'h0;
                        resp_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    mem_req    <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_extend_ctrl.sv
module tb_load_extend_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;

    int total = 0;
    int bad = 0;

    load_extend_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full load: accept, 'delay' MEM cycles without ack, ack, then handshake.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] rdata, input int delay,
                           input logic [31:0] exp_maddr, input logic [31:0] exp_data);
        chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_addr = addr; req_size = size; req_signed = sgn;
        tick();
        req_valid = 1'b0; req_addr = $urandom; req_size = 2'(size + 2'd1); req_signed = ~sgn;
        chk({tag, "_mem_req"}, {31'h0, mem_req}, 32'h1);
        chk({tag, "_mem_addr"}, mem_addr, exp_maddr);
        for (int i = 0; i < delay; i++) begin
            mem_rdata = $urandom;
            tick();
            chk({tag, "_wait_valid"}, {31'h0, resp_valid}, 32'h0);
        end
        mem_ack = 1'b1; mem_rdata = rdata;
        tick();
        mem_ack = 1'b0; mem_rdata = $urandom;
        chk({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h1);
        chk({tag, "_resp_data"}, resp_data, exp_data);
        chk({tag, "_resp_err"}, {31'h0, resp_err}, 32'h0);
        chk({tag, "_mem_req_drop"}, {31'h0, mem_req}, 32'h0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, "_done"}, {31'h0, resp_valid}, 32'h0);
    endtask

    // Illegal request: error response one cycle after accept, no memory access.
    task automatic do_err(input string tag, input logic [31:0] addr, input logic [1:0] size);
        req_valid = 1'b1; req_addr = addr; req_size = size; req_signed = 1'b1;
        tick();
        req_valid = 1'b0;
        chk({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
        chk({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h1);
        chk({tag, "_resp_err"}, {31'h0, resp_err}, 32'h1);
        chk({tag, "_resp_data"}, resp_data, 32'h0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, "_done"}, {31'h0, resp_valid}, 32'h0);
        chk({tag, "_no_mem"}, {31'h0, mem_req}, 32'h0);
    endtask

    initial begin
        #12;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        rst_n = 1'b1;
        tick();

        // ack in IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        chk("idle_ack_valid", {31'h0, resp_valid}, 32'h0);
        chk("idle_ack_ready", {31'h0, req_ready}, 32'h1);

        do_load("lb",   32'h0000_0103, 2'b00, 1'b1, 32'h81C1_1800, 3, 32'h0000_0100, 32'hFFFF_FF81);
        do_load("lbu",  32'h0000_0102, 2'b00, 1'b0, 32'h81C1_1800, 1, 32'h0000_0100, 32'h0000_00C1);
        do_load("lh",   32'h0000_0100, 2'b01, 1'b1, 32'h0000_FF59, 0, 32'h0000_0100, 32'hFFFF_FF59);
        do_load("lhu",  32'h0000_0100, 2'b01, 1'b0, 32'h0000_FF59, 2, 32'h0000_0100, 32'h0000_FF59);
        do_load("lw",   32'h0000_0104, 2'b10, 1'b1, 32'hDEAD_BEEF, 1, 32'h0000_0104, 32'hDEAD_BEEF);
        do_load("lh_hi", 32'hA000_0FFE, 2'b01, 1'b1, 32'h8001_7FFF, 0, 32'hA000_0FFC, 32'hFFFF_8001);
        do_load("lb_pos", 32'h0000_0201, 2'b00, 1'b1, 32'hFFFF_7FFF, 1, 32'h0000_0200, 32'h0000_007F);

        do_err("mis_lh", 32'h0000_0101, 2'b01);
        do_err("mis_lw", 32'h0000_0102, 2'b10);
        do_err("rsv_sz", 32'h0000_0100, 2'b11);

        // Backpressure: response held 5 cycles, second request waits.
        req_valid = 1'b1; req_addr = 32'h0000_0300; req_size = 2'b10; req_signed = 1'b0;
        tick();
        req_addr = 32'h0000_0401; req_size = 2'b00; req_signed = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'h0, resp_valid}, 32'h1);
            chk("bp_data", resp_data, 32'hCAFE_F00D);
            chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
            chk("bp_no_mem", {31'h0, mem_req}, 32'h0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("bp_hs_valid", {31'h0, resp_valid}, 32'h0);
        chk("bp_hs_no_turn", {31'h0, mem_req}, 32'h0);
        chk("bp_hs_ready", {31'h0, req_ready}, 32'h1);
        tick();
        req_valid = 1'b0;
        chk("bp_second_mem", {31'h0, mem_req}, 32'h1);
        chk("bp_second_addr", mem_addr, 32'h0000_0400);
        mem_ack = 1'b1; mem_rdata = 32'h0000_9A00;
        tick();
        mem_ack = 1'b0;
        chk("bp_second_data", resp_data, 32'hFFFF_FF9A);

        // resp_ready held high continuously across a load.
        resp_ready = 1'b1;
        tick();
        chk("rr_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_addr = 32'h0000_0502; req_size = 2'b01; req_signed = 1'b0;
        tick();
        req_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBEEF_0000;
        tick();
        mem_ack = 1'b0;
        chk("rr_valid", {31'h0, resp_valid}, 32'h1);
        chk("rr_data", resp_data, 32'h0000_BEEF);
        tick();
        chk("rr_done", {31'h0, resp_valid}, 32'h0);
        resp_ready = 1'b0;

        // Async reset mid-MEM, then a stray late ack.
        req_valid = 1'b1; req_addr = 32'h0000_0600; req_size = 2'b10;
        tick();
        req_valid = 1'b0;
        chk("rst_mid_mem_req", {31'h0, mem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_drop", {31'h0, mem_req}, 32'h0);
        chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        #3 rst_n = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("rst_stray_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_stray_memreq", {31'h0, mem_req}, 32'h0);

`ifdef LOAD_EXTEND_TIMEOUT_EN
        // No ack: timeout after 16 MEM cycles.
        req_valid = 1'b1; req_addr = 32'h0000_0700; req_size = 2'b10;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_waiting", {31'h0, mem_req}, 32'h1);
        end
        tick();
        chk("to_valid", {31'h0, resp_valid}, 32'h1);
        chk("to_err", {31'h0, resp_err}, 32'h1);
        chk("to_data", resp_data, 32'h0);
        chk("to_mem_drop", {31'h0, mem_req}, 32'h0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        // Ack on the 16th MEM cycle wins.
        req_valid = 1'b1; req_addr = 32'h0000_0700; req_size = 2'b10;
        tick();
        req_valid = 1'b0;
        repeat (15) tick();
        chk("to_edge_waiting", {31'h0, resp_valid}, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
        tick();
        mem_ack = 1'b0;
        chk("to_edge_valid", {31'h0, resp_valid}, 32'h1);
        chk("to_edge_err", {31'h0, resp_err}, 32'h0);
        chk("to_edge_data", resp_data, 32'h1357_9BDF);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
